reset_seq_gen: RTL



---
 rtl/reset_seq_pkg.sv | 18 +
 rtl/reset_seq_cnt.sv | 42 ++++
 rtl/reset_seq_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and default sizes for the reset sequence generator.
// The optional RESET_SEQ_ACK_EN build adds a dut_ready handshake.
package reset_seq_pkg;

  // Default width of the low/high phase length fields, in cycles.
  localparam int unsigned CNT_W_DEF = 8;
  // Default width of the pulse-count field.
  localparam int unsigned NUM_W_DEF = 4;

  // Sequencer states; WAIT_ACK is only reachable when RESET_SEQ_ACK_EN is defined.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    RELEASE  = 2'd2,
    WAIT_ACK = 2'd3
  } seq_state_e;

endpackage

// File: rtl/reset_seq_cnt.sv
// Loadable down-counter with terminal-count flag.
// The counter stops at zero; a load takes priority over a decrement.
module reset_seq_cnt
  import reset_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload, decrement toward zero, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared by the block reset.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/reset_seq_gen.sv
// Programmable active-low reset pulse-train generator with start/busy/done.
// Each pulse holds rst_out_l low for max(low_len,1) cycles, then high for
// max(high_len,1) cycles. Define RESET_SEQ_ACK_EN to add the dut_ready input
// and a WAIT_ACK state after every high phase.
module reset_seq_gen
  import reset_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] high_len,
  input  logic [NUM_W-1:0] num_pulses,
`ifdef RESET_SEQ_ACK_EN
  input  logic             dut_ready,
`endif
  output logic             rst_out_l,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_idx
);

  // Counter load value for a phase: zero-length phases last one cycle.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
    if (len == {CNT_W{1'b0}}) begin
      return {CNT_W{1'b0}};
    end else begin
      return len - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] low_q;
  logic [CNT_W-1:0] low_d;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] high_d;
  logic [NUM_W-1:0] num_q;
  logic [NUM_W-1:0] num_d;
  logic [NUM_W-1:0] idx_q;
  logic [NUM_W-1:0] idx_d;
  logic             rst_out_q;
  logic             busy_q;
  logic             done_q;
  logic             done_d;

  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             cnt_dec_s;
  logic             cnt_tc_s;
  logic             advance_s;
  logic             last_pulse_s;

  assign last_pulse_s = (idx_q == (num_q - {{(NUM_W-1){1'b0}}, 1'b1}));

  // Single phase counter, reloaded at every phase boundary.
  reset_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset_l    (reset_l),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .dec_i      (cnt_dec_s),
    .tc_o       (cnt_tc_s)
  );

  // Next-state, field capture and counter control for the pulse sequencer.
  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    high_d     = high_q;
    num_d      = num_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    cnt_load_s = 1'b0;
    cnt_val_s  = {CNT_W{1'b0}};
    cnt_dec_s  = 1'b0;
    advance_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_pulses != {NUM_W{1'b0}}) begin
            low_d      = low_len;
            high_d     = high_len;
            num_d      = num_pulses;
            idx_d      = {NUM_W{1'b0}};
            cnt_load_s = 1'b1;
            cnt_val_s  = phase_load(low_len);
            state_d    = ASSERT;
          end else begin
            // An empty request completes immediately without a pulse.
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ASSERT: begin
        if (cnt_tc_s) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = phase_load(high_q);
          state_d    = RELEASE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end

      RELEASE: begin
        if (cnt_tc_s) begin
`ifdef RESET_SEQ_ACK_EN
          state_d = WAIT_ACK;
`else
          advance_s = 1'b1;
`endif
        end else begin
          cnt_dec_s = 1'b1;
        end
      end

      WAIT_ACK: begin
`ifdef RESET_SEQ_ACK_EN
        if (dut_ready) begin
          advance_s = 1'b1;
        end else begin
          state_d = WAIT_ACK;
        end
`else
        state_d = IDLE;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // End of a high phase: next pulse, or finish the sequence.
    if (advance_s) begin
      if (last_pulse_s) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        idx_d      = idx_q + {{(NUM_W-1){1'b0}}, 1'b1};
        cnt_load_s = 1'b1;
        cnt_val_s  = phase_load(low_q);
        state_d    = ASSERT;
      end
    end else begin
      advance_s = 1'b0;
    end
  end

  // State, captured fields and pulse index registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      low_q   <= {CNT_W{1'b0}};
      high_q  <= {CNT_W{1'b0}};
      num_q   <= {NUM_W{1'b0}};
      idx_q   <= {NUM_W{1'b0}};
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      high_q  <= high_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
    end
  end

  // Registered outputs decoded from the next state so they change cleanly on the edge.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rst_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rst_out_q <= (state_d != ASSERT);
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
    end
  end

  assign rst_out_l = rst_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_idx = idx_q;

endmodule
